// File: rtl/l1_stream_pkg.sv
// Shared constants, widths and types for the L1 stream-pointer controller.
package l1_stream_pkg;

   localparam int unsigned lanes          = 8;
   localparam int unsigned words_per_line = 8;
   localparam int unsigned lines          = 4;

   localparam int unsigned outst_w = $clog2(lines + 1);
   localparam int unsigned avail_w = $clog2(lines * words_per_line + 1);
   // Wide enough for cap + words_per_line at full occupancy.
   localparam int unsigned cap_w   = $clog2((lines + 1) * words_per_line + 1);

   typedef logic [lanes-1:0]   lane_vec_t;
   typedef logic [outst_w-1:0] outst_t;
   typedef logic [avail_w-1:0] avail_t;
   typedef logic [cap_w-1:0]   cap_t;

   typedef struct packed {
      logic fetch;
      logic rsp;
      logic rd;
      logic flush;
   } evt_t;

   function automatic cap_t capacity(input outst_t o, input avail_t a);
      return cap_t'(o) * cap_t'(words_per_line) + cap_t'(a);
   endfunction

endpackage

// File: rtl/l1_stream_pointer_if.sv
// Read-lane, flush and cacheline request/response signals of one stream.
interface l1_stream_pointer_if;
   import l1_stream_pkg::*;

   lane_vec_t i_rd_v;
   lane_vec_t i_rd_r;
   logic      i_rst_v;
   logic      i_rst_r;
   logic      i_clrsp_v;
   logic      i_clrsp_r;
   logic      o_clreq_v;
   logic      o_clreq_r;

   modport slave (
      input  i_rd_v,
      output i_rd_r,
      input  i_rst_v,
      output i_rst_r,
      input  i_clrsp_v,
      output i_clrsp_r,
      output o_clreq_v,
      input  o_clreq_r
   );

   modport master (
      output i_rd_v,
      input  i_rd_r,
      output i_rst_v,
      input  i_rst_r,
      output i_clrsp_v,
      input  i_clrsp_r,
      input  o_clreq_v,
      output o_clreq_r
   );

endinterface

// File: rtl/l1_prio_arb.sv
// Lowest-index-first priority encoder with enable; one-hot (or zero) grant.
module l1_prio_arb #(
   parameter int unsigned width = 8
) (
   input  logic             en,
   input  logic [width-1:0] req,
   output logic [width-1:0] grant
);

   logic taken;

   always_comb begin
      grant = '0;
      taken = 1'b0;
      for (int unsigned k = 0; k < width; k++) begin
         if (en && req[k] && !taken) begin
            grant[k] = 1'b1;
            taken    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/l1_stream_pointer.sv
// Stream-pointer controller: tracks readable words and outstanding line
// fetches, prefetches to keep the buffer full, arbitrates reads, handles flush.
module l1_stream_pointer
   import l1_stream_pkg::*;
(
   input logic                clk,
   input logic                reset,
   l1_stream_pointer_if.slave bus
);

   avail_t    avail, avail_n;
   outst_t    outst, outst_n;
   cap_t      cap;
   lane_vec_t grant;
   logic      arb_en;
   evt_t      evt;

   always_comb begin
      cap    = capacity(outst, avail);
      arb_en = ~reset & ~bus.i_rst_v & (avail != '0);
   end

   l1_prio_arb #(.width(lanes)) u_arb (
      .en    (arb_en),
      .req   (bus.i_rd_v),
      .grant (grant)
   );

   // Outputs depend only on registered state and i_rst_v, never on o_clreq_r.
   always_comb begin
      bus.i_rd_r    = grant;
      bus.o_clreq_v = ~reset & ~bus.i_rst_v &
                      (cap + cap_t'(words_per_line) <= cap_t'(lines * words_per_line));
      bus.i_rst_r   = ~reset & (outst == '0);
      bus.i_clrsp_r = ~reset;
   end

   always_comb begin
      evt.fetch = bus.o_clreq_v & bus.o_clreq_r;
      evt.rsp   = bus.i_clrsp_v;
      evt.rd    = |grant;
      evt.flush = bus.i_rst_v & bus.i_rst_r;
   end

   always_comb begin
      outst_n = outst;
      unique case ({evt.fetch, evt.rsp})
         2'b10:   outst_n = outst + outst_t'(1);
         2'b01:   outst_n = outst - outst_t'(1);
         default: outst_n = outst;
      endcase

      // Response and read in one cycle net out; flush implies no response.
      if (evt.flush) begin
         avail_n = '0;
      end else begin
         avail_n = avail
                 + (evt.rsp ? avail_t'(words_per_line) : '0)
                 - (evt.rd  ? avail_t'(1) : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         avail <= '0;
         outst <= '0;
      end else begin
         avail <= avail_n;
         outst <= outst_n;
      end
   end

endmodule

// File: tb/tb_l1_stream_pointer.sv
// Scoreboard bench for l1_stream_pointer: expected outputs are pushed per cycle
// from a bench-side model and popped/compared on the falling edge.
module tb_l1_stream_pointer;

   typedef struct packed {
      logic       clreq_v;
      logic [7:0] rd_r;
      logic       rst_r;
      logic       clrsp_r;
   } exp_t;

   logic clk;
   logic reset;

   l1_stream_pointer_if bus ();

   l1_stream_pointer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   checks   = 0;
   int   failures = 0;
   int   m_avail  = 0;
   int   m_outst  = 0;
   int   cyc      = 0;
   int   due[$];
   exp_t sb[$];
   bit   auto_rsp  = 1'b1;
   int   rsp_delay = 2;
   bit   rsp_force = 1'b0;

   logic       last_clreq_v;
   logic [7:0] last_rd_r;
   logic       last_rst_r;
   logic       last_clrsp_r;
   logic       last_rsp;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got running required finished");
      $fatal(1, "watchdog");
   end

   function automatic exp_t compute();
      exp_t       e;
      int         cap;
      logic [7:0] v;
      e = '0;
      if (reset) return e;
      cap       = m_outst * 8 + m_avail;
      e.clreq_v = !bus.i_rst_v && (cap + 8 <= 32);
      v         = bus.i_rd_v;
      if (m_avail != 0 && !bus.i_rst_v) e.rd_r = v & (~v + 8'd1);
      e.rst_r   = (m_outst == 0);
      e.clrsp_r = 1'b1;
      return e;
   endfunction

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if ({bus.o_clreq_v, bus.i_rd_r, bus.i_rst_r, bus.i_clrsp_r} !== e) begin
            failures++;
            $display("FAIL outputs cyc=%0d: got clreq_v=%b rd_r=%b rst_r=%b clrsp_r=%b required clreq_v=%b rd_r=%b rst_r=%b clrsp_r=%b",
                     cyc, bus.o_clreq_v, bus.i_rd_r, bus.i_rst_r, bus.i_clrsp_r,
                     e.clreq_v, e.rd_r, e.rst_r, e.clrsp_r);
         end
         checks++;
         if ($countones(bus.i_rd_r) > 1) begin
            failures++;
            $display("FAIL onehot cyc=%0d: got rd_r=%b required at most one bit", cyc, bus.i_rd_r);
         end
      end
   end

   // One clock of stimulus: drive response, push expectation, advance model.
   task automatic tick();
      exp_t e;
      bit   fetch, rd, flush;
      bus.i_clrsp_v = 1'b0;
      if (auto_rsp ? (due.size() > 0 && due[0] <= cyc) : (rsp_force && due.size() > 0)) begin
         bus.i_clrsp_v = 1'b1;
         void'(due.pop_front());
      end
      e = compute();
      sb.push_back(e);
      @(negedge clk);
      last_clreq_v = bus.o_clreq_v;
      last_rd_r    = bus.i_rd_r;
      last_rst_r   = bus.i_rst_r;
      last_clrsp_r = bus.i_clrsp_r;
      last_rsp     = bus.i_clrsp_v;
      if (reset) begin
         m_avail = 0;
         m_outst = 0;
         due.delete();
      end else begin
         fetch = e.clreq_v && bus.o_clreq_r;
         rd    = (e.rd_r != 0);
         flush = bus.i_rst_v && e.rst_r;
         if (bus.i_clrsp_v) begin
            checks++;
            if (m_outst == 0) begin
               failures++;
               $display("FAIL rsp_legal cyc=%0d: got response with outst=%0d required outst>0", cyc, m_outst);
            end
         end
         if (fetch) due.push_back(cyc + rsp_delay);
         m_outst = m_outst + int'(fetch) - int'(bus.i_clrsp_v);
         m_avail = flush ? 0 : m_avail + 8 * int'(bus.i_clrsp_v) - int'(rd);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.i_rd_v = 8'hFF;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({last_clreq_v, last_rd_r, last_rst_r, last_clrsp_r} !== 11'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {last_clreq_v, last_rd_r, last_rst_r, last_clrsp_r});
         end
      end
      reset = 1'b0;
      bus.i_rd_v = '0;
      tick();
      checks++;
      if (last_clreq_v !== 1'b1 || last_rst_r !== 1'b1 || last_clrsp_r !== 1'b1 || last_rd_r !== 8'h00) begin
         failures++;
         $display("FAIL post_reset: got clreq_v=%b rst_r=%b clrsp_r=%b rd_r=%h required 1 1 1 00",
                  last_clreq_v, last_rst_r, last_clrsp_r, last_rd_r);
      end
   endtask

   task automatic test_fill();
      int n_fetch = 0;
      auto_rsp = 1'b1;
      rsp_delay = 2;
      bus.o_clreq_r = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (last_clreq_v) n_fetch++;
      end
      bus.o_clreq_r = 1'b0;
      checks++;
      if (n_fetch != 4) begin
         failures++;
         $display("FAIL fill_fetches: got %0d required 4", n_fetch);
      end
      checks++;
      if (last_clreq_v !== 1'b0) begin
         failures++;
         $display("FAIL fill_full_clreq: got %b required 0", last_clreq_v);
      end
   endtask

   task automatic test_read_drain();
      int first = -1;
      bus.o_clreq_r = 1'b0;
      bus.i_rd_v = 8'b1010_0100;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (last_rd_r !== 8'b0000_0100) begin
            failures++;
            $display("FAIL drain_grant i=%0d: got %b required 00000100", i, last_rd_r);
         end
         if (first < 0 && last_clreq_v) first = i;
      end
      checks++;
      if (first != 8) begin
         failures++;
         $display("FAIL drain_refetch_point: got %0d required 8", first);
      end
      bus.i_rd_v = 8'hFF;
      for (int n = 0; n < 40 && m_avail > 0; n++) tick();
      bus.i_rd_v = '0;
      checks++;
      if (m_avail != 0) begin
         failures++;
         $display("FAIL drain_empty: got avail=%0d required 0", m_avail);
      end
   endtask

   task automatic test_priority();
      int         rsp_at = -10;
      int         grant_at = -20;
      logic [7:0] g = '0;
      bus.i_rd_v = 8'hFF;
      tick();
      checks++;
      if (last_rd_r !== 8'h00) begin
         failures++;
         $display("FAIL prio_empty: got %b required 00000000", last_rd_r);
      end
      auto_rsp = 1'b1;
      rsp_delay = 2;
      bus.o_clreq_r = 1'b1;
      tick();
      bus.o_clreq_r = 1'b0;
      checks++;
      if (last_clreq_v !== 1'b1) begin
         failures++;
         $display("FAIL prio_fetch: got clreq_v=%b required 1", last_clreq_v);
      end
      for (int k = 0; k < 10; k++) begin
         tick();
         if (last_rsp) rsp_at = k;
         if (last_rd_r != 8'h00) begin
            grant_at = k;
            g = last_rd_r;
            break;
         end
      end
      bus.i_rd_v = '0;
      checks++;
      if (grant_at != rsp_at + 1 || g !== 8'h01) begin
         failures++;
         $display("FAIL prio_first_grant: got grant=%b at %0d (rsp at %0d) required 00000001 one cycle after response",
                  g, grant_at, rsp_at);
      end
   endtask

   task automatic test_read_with_rsp();
      int n = 0;
      auto_rsp = 1'b1;
      rsp_delay = 2;
      bus.o_clreq_r = 1'b1;
      for (int i = 0; i < 40 && (m_outst != 0 || m_avail < 5); i++) tick();
      bus.o_clreq_r = 1'b0;
      bus.i_rd_v = 8'h01;
      for (int i = 0; i < 40 && m_avail > 5; i++) tick();
      bus.i_rd_v = '0;
      auto_rsp = 1'b0;
      bus.o_clreq_r = 1'b1;
      tick();
      bus.o_clreq_r = 1'b0;
      checks++;
      if (last_clreq_v !== 1'b1) begin
         failures++;
         $display("FAIL rdrsp_fetch: got clreq_v=%b required 1", last_clreq_v);
      end
      bus.i_rd_v = 8'h01;
      rsp_force = 1'b1;
      tick();
      rsp_force = 1'b0;
      checks++;
      if (last_rd_r !== 8'h01) begin
         failures++;
         $display("FAIL rdrsp_same_cycle_grant: got %b required 00000001", last_rd_r);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         if (last_rd_r !== 8'h01) break;
         n++;
      end
      bus.i_rd_v = '0;
      checks++;
      if (n != 12) begin
         failures++;
         $display("FAIL rdrsp_avail: got %0d readable words required 12", n);
      end
      auto_rsp = 1'b1;
   endtask

   task automatic test_flush();
      auto_rsp = 1'b1;
      rsp_delay = 2;
      bus.o_clreq_r = 1'b1;
      for (int i = 0; i < 40 && !(m_avail == 32 && m_outst == 0); i++) tick();
      bus.o_clreq_r = 1'b0;
      bus.i_rd_v = 8'h01;
      for (int i = 0; i < 40 && m_avail > 16; i++) tick();
      bus.i_rd_v = '0;
      auto_rsp = 1'b0;
      bus.o_clreq_r = 1'b1;
      for (int i = 0; i < 5 && m_outst != 2; i++) tick();
      bus.o_clreq_r = 1'b0;
      checks++;
      if (m_outst != 2 || m_avail != 16) begin
         failures++;
         $display("FAIL flush_setup: got outst=%0d avail=%0d required 2 16", m_outst, m_avail);
      end
      bus.i_rst_v = 1'b1;
      bus.i_rd_v = 8'hFF;
      tick();
      checks++;
      if (last_clreq_v !== 1'b0 || last_rd_r !== 8'h00 || last_rst_r !== 1'b0) begin
         failures++;
         $display("FAIL flush_block: got clreq_v=%b rd_r=%b rst_r=%b required 0 00000000 0",
                  last_clreq_v, last_rd_r, last_rst_r);
      end
      rsp_force = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (last_rst_r !== 1'b0) begin
            failures++;
            $display("FAIL flush_wait i=%0d: got rst_r=%b required 0", i, last_rst_r);
         end
      end
      rsp_force = 1'b0;
      tick();
      checks++;
      if (last_rst_r !== 1'b1) begin
         failures++;
         $display("FAIL flush_accept: got rst_r=%b required 1", last_rst_r);
      end
      bus.i_rst_v = 1'b0;
      tick();
      checks++;
      if (last_rd_r !== 8'h00 || last_clreq_v !== 1'b1) begin
         failures++;
         $display("FAIL flush_after: got rd_r=%b clreq_v=%b required 00000000 1", last_rd_r, last_clreq_v);
      end
      bus.i_rd_v = '0;
      auto_rsp = 1'b1;
   endtask

   task automatic test_soak();
      bit flushing = 1'b0;
      int n_start = 0;
      int n_done = 0;
      auto_rsp = 1'b1;
      rsp_delay = 1;
      for (int i = 0; i < 10000; i++) begin
         if (i % 256 == 0 && !flushing) begin
            flushing = 1'b1;
            n_start++;
         end
         bus.i_rst_v   = flushing;
         bus.i_rd_v    = 8'($urandom);
         bus.o_clreq_r = 1'($urandom_range(0, 1));
         tick();
         if (flushing && last_rst_r) begin
            flushing = 1'b0;
            n_done++;
         end
      end
      bus.i_rst_v = 1'b0;
      bus.i_rd_v = '0;
      bus.o_clreq_r = 1'b0;
      checks++;
      if (n_done < n_start - 1 || n_done < 1) begin
         failures++;
         $display("FAIL soak_flushes: got %0d completed required at least %0d", n_done, n_start - 1);
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.i_rd_v = '0;
      bus.i_rst_v = 1'b0;
      bus.i_clrsp_v = 1'b0;
      bus.o_clreq_r = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_fill();
      test_read_drain();
      test_priority();
      test_read_with_rsp();
      test_flush();
      test_soak();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/l1_stream_pointer.md
Name: l1_stream_pointer

Overview:
- Stream-pointer controller for one stream of the L1 multi-stream buffer.
- Tracks how many buffered words are readable and how many cacheline fetches are outstanding.
- Prefetches cachelines to keep the buffer full, arbitrates up to 8 read lanes (one word per cycle), and supports a flush handshake that empties the stream.
- Sits between the read consumers and the cacheline request/response channel of the lower memory level.

Parameters:
- lanes, 8, number of read lanes (width of i_rd_v and i_rd_r).
- words_per_line, 8, words delivered by one cacheline response.
- lines, 4, buffer capacity in cachelines; caps outstanding plus held data.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_rd_v  in  lanes  per-lane read request, one word each.
- i_rd_r  out  lanes  per-lane read grant; a read transfers when i_rd_v[k]&i_rd_r[k].
- i_rst_v  in  1  stream flush request.
- i_rst_r  out  1  flush accept.
- i_clrsp_v  in  1  cacheline response valid; returns one line, in order.
- i_clrsp_r  out  1  response ready.
- o_clreq_v  out  1  cacheline fetch request valid.
- o_clreq_r  in  1  downstream accepts the fetch.

Behaviour:
- State registers:
  - avail: readable words, 0..lines*words_per_line.
  - outst: outstanding fetches, 0..lines.
- Reset: avail=0, outst=0. While reset is high, all outputs are 0. After reset: o_clreq_v=1 unless i_rst_v=1; i_rst_r=1.
- Capacity:
  - Let cap = outst*words_per_line + avail.
  - o_clreq_v = ~i_rst_v & (cap + words_per_line <= lines*words_per_line).
  - o_clreq_v depends only on registered state and i_rst_v, never on o_clreq_r.
- Fetch fire (o_clreq_v&o_clreq_r): outst+1 next cycle.
- Response:
  - i_clrsp_r = 1 constantly.
  - On i_clrsp_v: outst-1 and avail+words_per_line.
  - i_clrsp_v with outst==0 is illegal; the bench asserts on it.
- Read arbitration:
  - Fixed priority, lowest index wins.
  - i_rd_r[k] = (avail!=0) & ~i_rst_v & i_rd_v[k] & no lower lane valid.
  - At most one grant per cycle. A granted read decrements avail by 1 next cycle.
  - Latency from response to readable: 1 cycle.
- Simultaneous events (net updates add):
  - Read and response in the same cycle: avail += words_per_line-1.
  - Fetch and response in the same cycle: outst unchanged.
- Flush:
  - i_rst_r = (outst==0).
  - While i_rst_v is pending, new fetches and reads are blocked so outstanding responses drain.
  - On i_rst_v&i_rst_r: avail=0 next cycle. outst is already 0.
  - Flush has priority over a same-cycle response; that cannot occur because outst==0 when flush is accepted.
- Counters never wrap: the capacity rule bounds outst and avail; avail never underflows because reads require avail!=0.
- Reset asserted mid-operation clears everything in one cycle. Outstanding responses arriving after reset are illegal; the environment must drain or reset the memory side too.

Decomposition:
- Shared package l1_stream_pkg: lanes, words_per_line, lines, and derived widths $clog2(lines+1) and $clog2(lines*words_per_line+1).
- One sub-module: l1_prio_arb, a lanes-wide lowest-index-first priority encoder with enable, producing a one-hot grant.

Test Plan:
- Reset then no traffic, o_clreq_r=1, response 2 cycles after each request:
  - o_clreq_v pulses until cap=32 (4 fetches).
  - Then outst=0, avail=32, o_clreq_v=0.
- With avail=32, i_rd_v=8'b1010_0100 held:
  - i_rd_r=8'b0000_0100 each cycle; avail drops by 1 per cycle.
  - Once avail<=24, o_clreq_v=1.
- Lane priority with avail=0: i_rd_v=8'hFF gives i_rd_r=0. After one response, next cycle i_rd_r=8'h01.
- Same-cycle read plus response at avail=5: avail=12 next cycle.
- Flush with outst=2, i_rst_v=1:
  - o_clreq_v=0 and i_rd_r=0 immediately; i_rst_r=0.
  - After 2 responses, i_rst_r=1, handshake; avail=0 next cycle.
  - Fetching resumes once i_rst_v drops.
- Random soak, 100000 ns:
  - Random i_rd_v each cycle; periodic flush every 256 cycles; responses from a 1-deep register slice.
  - No counter overflow or underflow; at most one bit of i_rd_r set; no response with outst==0.
